reorder_buffer_mc: RTL and testbench

REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

---
 rtl/reorder_buffer_mc_pkg.sv | 41 ++++
 rtl/rob_commit_class.sv | 21 ++
 rtl/reorder_buffer_mc.sv | 278 +++++++++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_mc_pkg.sv
// rtl/reorder_buffer_mc_pkg.sv - shared op encodings, commit classes, store sizes and store FSM states
package reorder_buffer_mc_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ALU    = 4'd0;
    localparam logic [OP_W-1:0] OP_LOAD   = 4'd1;
    localparam logic [OP_W-1:0] OP_JAL    = 4'd2;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'd3;
    localparam logic [OP_W-1:0] OP_JALR   = 4'd4;
    localparam logic [OP_W-1:0] OP_SB     = 4'd5;
    localparam logic [OP_W-1:0] OP_SH     = 4'd6;
    localparam logic [OP_W-1:0] OP_SW     = 4'd7;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JALR   = 2'd2,
        CLS_STORE  = 2'd3
    } commit_class_e;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } store_state_e;

    // Byte count of a store op; anything that is not SB/SH is a word store.
    function automatic logic [2:0] store_size(input logic [OP_W-1:0] op);
        case (op)
            OP_SB:   return SIZE_B;
            OP_SH:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/rob_commit_class.sv
// rtl/rob_commit_class.sv - combinational op-to-commit-class decoder, one per commit slot
//   op  : entry opcode (OP_W)
//   cls : commit class (ALU / BRANCH / JALR / STORE)
module rob_commit_class
    import reorder_buffer_mc_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output commit_class_e   cls
);

    always_comb begin
        cls = CLS_ALU;
        case (op)
            OP_BRANCH:           cls = CLS_BRANCH;
            OP_JALR:             cls = CLS_JALR;
            OP_SB, OP_SH, OP_SW: cls = CLS_STORE;
            default:             cls = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// rtl/reorder_buffer_mc.sv - in-order commit reorder buffer with branch resolve, JALR flush and store sequencing
//   clk, rst (sync, active-low), rdy (global enable)
//   alloc_*  : allocation at tail; alloc_ready = not full, alloc_tag = tail index
//   wb_*     : WB_PORTS writeback ports (tag, value, aux = new PC / store address)
//   cmt_*    : two commit slots, slot 1 only with ROB_DUAL_COMMIT_EN defined
//   mem_*    : store request/handshake
//   bp_*     : branch resolution report; flush/flush_pc : one-cycle redirect
//   count    : occupancy
// Optional feature macro: ROB_DUAL_COMMIT_EN (second ALU-class commit per cycle)
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    localparam int TAG_W   = $clog2(DEPTH),
    localparam int CW      = TAG_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      alloc_valid,
    input  logic [OP_W-1:0]           alloc_op,
    input  logic [4:0]                alloc_rd,
    input  logic [31:0]               alloc_pc,
    input  logic                      alloc_pred,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    input  logic [WB_PORTS*32-1:0]    wb_aux,
    output logic [1:0]                cmt_valid,
    output logic [2*5-1:0]            cmt_rd,
    output logic [2*32-1:0]           cmt_value,
    output logic [2*TAG_W-1:0]        cmt_tag,
    output logic                      mem_req,
    output logic [2:0]                mem_size,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_data,
    input  logic                      mem_done,
    output logic                      bp_valid,
    output logic                      bp_taken,
    output logic [31:0]               bp_pc,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic [CW-1:0]             count
);

    // Entry storage
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      ready_q;
    logic [OP_W-1:0]       op_q    [DEPTH];
    logic [4:0]            rd_q    [DEPTH];
    logic [31:0]           pc_q    [DEPTH];
    logic                  pred_q  [DEPTH];
    logic [31:0]           value_q [DEPTH];
    logic [31:0]           aux_q   [DEPTH];

    logic [TAG_W-1:0]      head_q;
    logic [TAG_W-1:0]      tail_q;

    store_state_e          state_q;
    store_state_e          state_d;
    logic                  store_start;
    logic                  store_retire;

    commit_class_e         cls0;
    logic                  head_ok;
    logic                  commit0;
    logic                  commit1;
    logic                  retire0;
    logic                  do_flush;
    logic [31:0]           flush_target;
    logic                  alloc_fire;
    logic [1:0]            n_retire;

    logic [TAG_W-1:0]      wb_tag_a [WB_PORTS];
    logic [31:0]           wb_val_a [WB_PORTS];
    logic [31:0]           wb_aux_a [WB_PORTS];
    logic [WB_PORTS-1:0]   wb_hit;

    assign alloc_ready = (count < CW'(DEPTH));
    assign alloc_tag   = tail_q;

    // The registered flush output doubles as the "flush cycle" marker:
    // while it is high nothing commits, allocates or writes back.
    assign alloc_fire = rdy && alloc_valid && alloc_ready && !flush;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
        assign wb_tag_a[p] = wb_tag[p*TAG_W +: TAG_W];
        assign wb_val_a[p] = wb_value[p*32 +: 32];
        assign wb_aux_a[p] = wb_aux[p*32 +: 32];
        assign wb_hit[p]   = wb_valid[p] && valid_q[wb_tag_a[p]] && !flush;
    end

    rob_commit_class u_cls0 (
        .op  (op_q[head_q]),
        .cls (cls0)
    );

    // Ready is registered, so a writeback to the head only becomes visible
    // to commit on the following cycle.
    assign head_ok = !flush && (state_q == ST_IDLE) && valid_q[head_q] && ready_q[head_q];
    assign commit0 = head_ok && (cls0 != CLS_STORE);

    assign do_flush = commit0 &&
                      ((cls0 == CLS_JALR) ||
                       ((cls0 == CLS_BRANCH) && (value_q[head_q][0] != pred_q[head_q])));

    always_comb begin
        flush_target = aux_q[head_q];
        if ((cls0 == CLS_BRANCH) && !value_q[head_q][0]) begin
            flush_target = pc_q[head_q] + 32'd4;
        end
    end

`ifdef ROB_DUAL_COMMIT_EN
    logic [TAG_W-1:0] head1;
    commit_class_e    cls1;

    assign head1 = head_q + TAG_W'(1);

    rob_commit_class u_cls1 (
        .op  (op_q[head1]),
        .cls (cls1)
    );

    // Slot 1 is only used when both heads are plain register writers, so a
    // pair never mixes with a redirect or a memory sequence.
    assign commit1 = head_ok && (cls0 == CLS_ALU) &&
                     valid_q[head1] && ready_q[head1] && (cls1 == CLS_ALU);
`else
    assign commit1 = 1'b0;
`endif

    // Store FSM: next state
    always_comb begin
        state_d      = state_q;
        store_start  = 1'b0;
        store_retire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_ok && (cls0 == CLS_STORE)) begin
                    state_d     = ST_REQ;
                    store_start = 1'b1;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done && !flush) begin
                    state_d      = ST_IDLE;
                    store_retire = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            store_start  = 1'b0;
            store_retire = 1'b0;
        end
    end

    // Store FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    assign retire0  = commit0 || store_retire;
    assign n_retire = {1'b0, retire0} + {1'b0, commit1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= '0;
            ready_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count     <= '0;
            cmt_valid <= '0;
            cmt_rd    <= '0;
            cmt_value <= '0;
            cmt_tag   <= '0;
            mem_req   <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            bp_valid  <= 1'b0;
            bp_taken  <= 1'b0;
            bp_pc     <= '0;
            flush     <= 1'b0;
            flush_pc  <= '0;
        end else if (rdy) begin
            cmt_valid <= '0;
            bp_valid  <= 1'b0;
            mem_req   <= 1'b0;
            flush     <= 1'b0;
            if (flush) begin
                valid_q <= '0;
                ready_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count   <= '0;
            end else begin
                // Highest port first so the lowest port's write lands last and wins.
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_hit[p]) begin
                        ready_q[wb_tag_a[p]] <= 1'b1;
                        value_q[wb_tag_a[p]] <= wb_val_a[p];
                        aux_q[wb_tag_a[p]]   <= wb_aux_a[p];
                    end
                end

                if (retire0) begin
                    valid_q[head_q] <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end

`ifdef ROB_DUAL_COMMIT_EN
                if (commit1) begin
                    valid_q[head1]     <= 1'b0;
                    ready_q[head1]     <= 1'b0;
                    cmt_valid[1]       <= 1'b1;
                    cmt_rd[9:5]        <= rd_q[head1];
                    cmt_value[63:32]   <= value_q[head1];
                    cmt_tag[2*TAG_W-1:TAG_W] <= head1;
                end
`endif

                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    op_q[tail_q]    <= alloc_op;
                    rd_q[tail_q]    <= alloc_rd;
                    pc_q[tail_q]    <= alloc_pc;
                    pred_q[tail_q]  <= alloc_pred;
                    tail_q          <= tail_q + TAG_W'(1);
                end

                head_q <= head_q + TAG_W'(n_retire);
                count  <= count + CW'(alloc_fire) - CW'(n_retire);

                if (commit0 && (cls0 != CLS_BRANCH)) begin
                    cmt_valid[0]          <= 1'b1;
                    cmt_rd[4:0]           <= rd_q[head_q];
                    cmt_value[31:0]       <= value_q[head_q];
                    cmt_tag[TAG_W-1:0]    <= head_q;
                end

                if (commit0 && (cls0 == CLS_BRANCH)) begin
                    bp_valid <= 1'b1;
                    bp_taken <= value_q[head_q][0];
                    bp_pc    <= pc_q[head_q];
                end

                if (do_flush) begin
                    flush    <= 1'b1;
                    flush_pc <= flush_target;
                end

                if (store_start) begin
                    mem_req  <= 1'b1;
                    mem_size <= store_size(op_q[head_q]);
                    mem_addr <= aux_q[head_q];
                    mem_data <= value_q[head_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb/tb_reorder_buffer_mc.sv - scoreboard bench for reorder_buffer_mc
module tb_reorder_buffer_mc;
    import reorder_buffer_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [3:0]  alloc_op;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_tag;
    logic [63:0] wb_value;
    logic [63:0] wb_aux;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_rd;
    logic [63:0] cmt_value;
    logic [7:0]  cmt_tag;
    logic        mem_req;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;
    logic        bp_valid;
    logic        bp_taken;
    logic [31:0] bp_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  count;

    reorder_buffer_mc #(.DEPTH(16), .WB_PORTS(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_aux(wb_aux),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_value(cmt_value), .cmt_tag(cmt_tag),
        .mem_req(mem_req), .mem_size(mem_size), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_done(mem_done),
        .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_pc(bp_pc),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] value; logic [3:0] tag; } cmt_t;
    typedef struct packed { logic taken; logic [31:0] pc; } bp_t;
    typedef struct packed { logic [2:0] size; logic [31:0] addr; logic [31:0] data; } mem_t;

    cmt_t        q_cmt[$];
    bp_t         q_bp[$];
    mem_t        q_mem[$];
    logic [31:0] q_flush[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_cv;
    logic [4:0] exp_cnt;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [95:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got=%0h required=no output", name, got);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output pulse.
    cmt_t        m_cmt;
    bp_t         m_bp;
    mem_t        m_mem;
    logic [31:0] m_fl;
    always @(negedge clk) begin
        if (cmt_valid[0]) begin
            if (q_cmt.size() == 0) unexpected("cmt0_extra", {cmt_rd[4:0], cmt_value[31:0], cmt_tag[3:0]});
            else begin
                m_cmt = q_cmt.pop_front();
                check("cmt0", {cmt_rd[4:0], cmt_value[31:0], cmt_tag[3:0]}, m_cmt);
            end
        end
        if (cmt_valid[1]) begin
            if (q_cmt.size() == 0) unexpected("cmt1_extra", {cmt_rd[9:5], cmt_value[63:32], cmt_tag[7:4]});
            else begin
                m_cmt = q_cmt.pop_front();
                check("cmt1", {cmt_rd[9:5], cmt_value[63:32], cmt_tag[7:4]}, m_cmt);
            end
        end
        if (bp_valid) begin
            if (q_bp.size() == 0) unexpected("bp_extra", {bp_taken, bp_pc});
            else begin
                m_bp = q_bp.pop_front();
                check("bp", {bp_taken, bp_pc}, m_bp);
            end
        end
        if (mem_req) begin
            if (q_mem.size() == 0) unexpected("mem_extra", {mem_size, mem_addr, mem_data});
            else begin
                m_mem = q_mem.pop_front();
                check("mem", {mem_size, mem_addr, mem_data}, m_mem);
            end
        end
        if (flush) begin
            if (q_flush.size() == 0) unexpected("flush_extra", flush_pc);
            else begin
                m_fl = q_flush.pop_front();
                check("flush_pc", flush_pc, m_fl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_alloc(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        alloc_valid = 1'b1;
        alloc_op    = op;
        alloc_rd    = rd;
        alloc_pc    = pc;
        alloc_pred  = pred;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input int p, input logic [3:0] tag, input logic [31:0] val, input logic [31:0] aux);
        wb_valid            = 2'b00;
        wb_valid[p]         = 1'b1;
        wb_tag[p*4 +: 4]    = tag;
        wb_value[p*32 +: 32] = val;
        wb_aux[p*32 +: 32]  = aux;
        tick();
        wb_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_op = '0; alloc_rd = '0; alloc_pc = '0; alloc_pred = 1'b0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_aux = '0; mem_done = 1'b0;

        // Reset state
        do_reset();
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_count", count, 0);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_outputs", {cmt_valid, bp_valid, mem_req, flush, flush_pc}, 0);

        // Fill and wrap
        for (int i = 0; i < 16; i++) begin
            check("fill_tag", alloc_tag, i);
            do_alloc(OP_ALU, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b0);
        end
        check("full_alloc_ready", alloc_ready, 0);
        check("full_count", count, 16);
        do_alloc(OP_ALU, 5'd30, 32'h999, 1'b0);
        check("17th_ignored_count", count, 16);
        check("17th_ignored_tail", alloc_tag, 0);
        // rdy low: writeback must not be captured
        rdy = 1'b0;
        do_wb(0, 4'd0, 32'hBAD, 32'h0);
        rdy = 1'b1;
        tick();
        tick();
        check("rdy_hold_no_commit", cmt_valid, 0);
        check("rdy_hold_count", count, 16);
        q_cmt.push_back('{rd: 5'd1, value: 32'hA0, tag: 4'd0});
        do_wb(0, 4'd0, 32'hA0, 32'h0);
        check("wb_to_head_not_same_cycle", cmt_valid, 0);
        tick();
        check("head_commit_pulse", cmt_valid[0], 1);
        check("after_commit_count", count, 15);
        check("after_commit_ready", alloc_ready, 1);
        check("reissue_tag0", alloc_tag, 0);
        do_alloc(OP_ALU, 5'd17, 32'h140, 1'b0);
        check("refill_count", count, 16);

        // Dual commit
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(OP_ALU, 5'(10 + i), 32'h200 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            q_cmt.push_back('{rd: 5'(10 + i), value: 32'h10 + 32'(i), tag: 4'(i)});
            do_wb(0, 4'(i), 32'h10 + 32'(i), 32'h0);
        end
        tick(); tick(); tick();
        check("dual_pre_count", count, 2);
        q_cmt.push_back('{rd: 5'd13, value: 32'h33, tag: 4'd3});
        q_cmt.push_back('{rd: 5'd14, value: 32'h44, tag: 4'd4});
        wb_valid = 2'b11;
        wb_tag   = {4'd4, 4'd3};
        wb_value = {32'h44, 32'h33};
        wb_aux   = '0;
        tick();
        wb_valid = 2'b00;
        check("dual_not_same_cycle", cmt_valid, 0);
        tick();
`ifdef ROB_DUAL_COMMIT_EN
        exp_cv = 2'b11; exp_cnt = 5'd0;
`else
        exp_cv = 2'b01; exp_cnt = 5'd1;
`endif
        check("dual_cmt_valid", cmt_valid, exp_cv);
        check("dual_count", count, exp_cnt);
        tick();
        check("dual_drained", count, 0);

        // Store sequence
        do_reset();
        do_alloc(OP_SW, 5'd0, 32'h300, 1'b0);
        q_mem.push_back('{size: 3'd4, addr: 32'h1000, data: 32'hDEADBEEF});
        do_wb(0, 4'd0, 32'hDEADBEEF, 32'h1000);
        check("st_req_not_yet", mem_req, 0);
        tick();
        check("st_req_high", mem_req, 1);
        tick();
        check("st_req_one_cycle", mem_req, 0);
        tick(); tick();
        check("st_wait_count", count, 1);
        mem_done = 1'b1;
        check("st_not_retired_during_done", count, 1);
        tick();
        mem_done = 1'b0;
        check("st_retired", count, 0);
        check("st_no_second_req", mem_req, 0);

        // Mispredicted branch
        do_reset();
        do_alloc(OP_BRANCH, 5'd0, 32'h400, 1'b0);
        do_alloc(OP_ALU, 5'd3, 32'h404, 1'b0);
        q_bp.push_back('{taken: 1'b1, pc: 32'h400});
        q_flush.push_back(32'h200);
        do_wb(0, 4'd0, 32'h1, 32'h200);
        tick();
        check("mp_bp_valid", {bp_valid, bp_taken}, 2'b11);
        check("mp_flush", flush, 1);
        do_wb(0, 4'd1, 32'h77, 32'h0);
        check("mp_flush_one_cycle", flush, 0);
        check("mp_count_zero", count, 0);
        check("mp_tail_zero", alloc_tag, 0);
        tick(); tick();

        // JALR: commit plus redirect to aux
        do_alloc(OP_JALR, 5'd7, 32'h500, 1'b0);
        q_cmt.push_back('{rd: 5'd7, value: 32'h504, tag: 4'd0});
        q_flush.push_back(32'h800);
        do_wb(1, 4'd0, 32'h504, 32'h800);
        tick(); tick(); tick();
        check("jalr_count", count, 0);
        check("jalr_tail_reset", alloc_tag, 0);

        // Correctly predicted branch: report only, no redirect
        do_alloc(OP_BRANCH, 5'd0, 32'h600, 1'b1);
        q_bp.push_back('{taken: 1'b1, pc: 32'h600});
        do_wb(0, 4'd0, 32'h1, 32'h700);
        tick(); tick(); tick();
        check("bp_ok_count", count, 0);
        check("bp_ok_tail_kept", alloc_tag, 1);

        // Same-tag writeback conflict: port 0 wins
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(OP_ALU, 5'(20 + i), 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) q_cmt.push_back('{rd: 5'(20 + i), value: 32'h50 + 32'(i), tag: 4'(i)});
        q_cmt.push_back('{rd: 5'd25, value: 32'h55, tag: 4'd5});
        wb_valid = 2'b11;
        wb_tag   = {4'd5, 4'd5};
        wb_value = {32'h66, 32'h55};
        wb_aux   = '0;
        tick();
        wb_valid = 2'b00;
        for (int i = 0; i < 5; i++) do_wb(0, 4'(i), 32'h50 + 32'(i), 32'h0);
        tick(); tick(); tick();
        check("conflict_drained", count, 0);

        // Reset during WAIT, with rdy low
        do_reset();
        do_alloc(OP_SH, 5'd0, 32'h700, 1'b0);
        q_mem.push_back('{size: 3'd2, addr: 32'h2000, data: 32'hCAFE0001});
        do_wb(0, 4'd0, 32'hCAFE0001, 32'h2000);
        tick();
        check("rw_req_high", mem_req, 1);
        tick();
        check("rw_in_wait", {mem_req, count}, {1'b0, 5'd1});
        rdy = 1'b0;
        rst = 1'b0;
        tick();
        check("rw_mem_req_low", mem_req, 0);
        check("rw_count_zero", count, 0);
        check("rw_alloc_ready", alloc_ready, 1);
        rst = 1'b1;
        rdy = 1'b1;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick();
        check("rw_after_done", {mem_req, count, alloc_tag}, 0);

        tick(); tick();
        check("scoreboard_drained", q_cmt.size() + q_bp.size() + q_mem.size() + q_flush.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
